// File: rtl/nn_pkg.sv
// Shared types and saturating-step helpers for the stochastic gradient nodes.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Working width for the generic helpers; counters up to 31 bits are covered.
   localparam int SAT_W = 32;

   typedef struct packed {
      logic [SAT_W-1:0] val;
      logic             ovf;
   } sat_res_t;

   function automatic logic signed [SAT_W-1:0] sat_max(input int nb);
      logic signed [SAT_W-1:0] one;
      one = 1;
      return (one <<< (nb - 1)) - 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_min(input int nb);
      logic signed [SAT_W-1:0] one;
      one = 1;
      return -(one <<< (nb - 1));
   endfunction

   // nb-bit signed value plus a step in {-1,0,+1}, clamped to the nb-bit range.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] val,
                                        input int nb,
                                        input logic signed [1:0] step);
      logic signed [SAT_W-1:0] s;
      sat_res_t                r;
      s     = val + SAT_W'(step);
      r.val = s;
      r.ovf = 1'b0;
      if (s > sat_max(nb)) begin
         r.val = sat_max(nb);
         r.ovf = 1'b1;
      end else if (s < sat_min(nb)) begin
         r.val = sat_min(nb);
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nn_grad_chan.sv
// One gradient channel: split-unipolar step decode and a saturating signed counter.
module nn_grad_chan
   import nn_pkg::*;
#(
   parameter int NB = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 a_i,
   input  logic                 delta_p_i,
   input  logic                 delta_n_i,
   input  logic                 en_i,
   input  logic                 clr_i,
   output logic signed [NB-1:0] count_o,
   output logic                 sat_o
);

   logic signed [NB-1:0] cnt_q, cnt_d;
   logic                 sat_q, sat_d;
   logic signed [1:0]    step;
   sat_res_t             res;

   always_comb begin
      step = 2'sd0;
      if (a_i & delta_p_i & ~delta_n_i)      step = 2'sd1;
      else if (a_i & delta_n_i & ~delta_p_i) step = -2'sd1;
      res   = sat_add(SAT_W'(cnt_q), NB, step);
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr_i) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (en_i) begin
         cnt_d = NB'(res.val);
         sat_d = sat_q | res.ovf;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   // Count including this cycle's step, so the final sample lands in the result word.
   assign count_o = cnt_d;
   assign sat_o   = sat_q;

endmodule

// File: rtl/nn_dnode_acc.sv
// Windowed backprop gradient node: NN alpha channels plus one beta channel,
// integrated over 2^WIN_LOG2 enabled samples and handed off via valid/ready.
module nn_dnode_acc
   import nn_pkg::*;
#(
   parameter int NN       = 3,
   parameter int NB       = 16,
   parameter int WIN_LOG2 = 8
) (
   input  logic             CLK,
   input  logic             INIT,
   input  logic             start,
   input  logic             en,
   input  logic             delta_p,
   input  logic             delta_n,
   input  logic [NN-1:0]    atj,
   output logic [NN*NB-1:0] grad_alpha,
   output logic [NB-1:0]    grad_beta,
   output logic             grad_valid,
   input  logic             grad_ready,
   output logic             busy,
   output logic [NN:0]      sat
);

   state_t                 st_q, st_d;
   logic [WIN_LOG2-1:0]    wcnt_q, wcnt_d;
   logic [NN*NB-1:0]       ga_q;
   logic [NB-1:0]          gb_q;
   logic                   clr, acc_en, last;
   logic [NN:0]            a_vec;
   logic [NN:0][NB-1:0]    cnt;

   // Beta is the same counter with its activation tied high.
   assign a_vec = {1'b1, atj};

   for (genvar n = 0; n <= NN; n++) begin : g_chan
      nn_grad_chan #(.NB(NB)) u_chan (
         .clk_i     (CLK),
         .rst_ni    (INIT),
         .a_i       (a_vec[n]),
         .delta_p_i (delta_p),
         .delta_n_i (delta_n),
         .en_i      (acc_en),
         .clr_i     (clr),
         .count_o   (cnt[n]),
         .sat_o     (sat[n])
      );
   end

   always_comb begin
      acc_en = (st_q == ACCUM) && en;
      last   = acc_en && (&wcnt_q);
      clr    = start && ((st_q == IDLE) || ((st_q == DONE) && grad_ready));
      st_d   = st_q;
      case (st_q)
         IDLE:    if (start) st_d = ACCUM;
         ACCUM:   if (last)  st_d = DONE;
         DONE:    if (grad_ready) st_d = start ? ACCUM : IDLE;
         default: st_d = IDLE;
      endcase
      wcnt_d = wcnt_q;
      if (clr)         wcnt_d = '0;
      else if (acc_en) wcnt_d = wcnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge INIT) begin
      if (!INIT) begin
         st_q   <= IDLE;
         wcnt_q <= '0;
         ga_q   <= '0;
         gb_q   <= '0;
      end else begin
         st_q   <= st_d;
         wcnt_q <= wcnt_d;
         if (last) begin
            ga_q <= cnt[NN-1:0];
            gb_q <= cnt[NN];
         end
      end
   end

   assign grad_alpha = ga_q;
   assign grad_beta  = gb_q;
   assign grad_valid = (st_q == DONE);
   assign busy       = (st_q == ACCUM) || (st_q == DONE);

endmodule

// File: tb/tb_nn_dnode_acc.sv
// Directed bench: instance A (NB=8, W=8) for function/timing, instance S (NB=4, W=16) for saturation.
module tb_nn_dnode_acc;

   logic        CLK = 1'b0;
   logic        INIT;
   logic        start_a, start_s, ready_a, ready_s;
   logic        en, delta_p, delta_n;
   logic [2:0]  atj;
   logic [23:0] galpha_a;
   logic [7:0]  gbeta_a;
   logic        valid_a, busy_a;
   logic [3:0]  sat_a;
   logic [11:0] galpha_s;
   logic [3:0]  gbeta_s;
   logic        valid_s, busy_s;
   logic [3:0]  sat_s;

   int npass = 0;
   int ntot  = 0;

   always #5 CLK = ~CLK;

   nn_dnode_acc #(.NN(3), .NB(8), .WIN_LOG2(3)) u_a (
      .CLK(CLK), .INIT(INIT), .start(start_a), .en(en), .delta_p(delta_p), .delta_n(delta_n),
      .atj(atj), .grad_alpha(galpha_a), .grad_beta(gbeta_a), .grad_valid(valid_a),
      .grad_ready(ready_a), .busy(busy_a), .sat(sat_a)
   );

   nn_dnode_acc #(.NN(3), .NB(4), .WIN_LOG2(4)) u_s (
      .CLK(CLK), .INIT(INIT), .start(start_s), .en(en), .delta_p(delta_p), .delta_n(delta_n),
      .atj(atj), .grad_alpha(galpha_s), .grad_beta(gbeta_s), .grad_valid(valid_s),
      .grad_ready(ready_s), .busy(busy_s), .sat(sat_s)
   );

   typedef struct {
      logic [2:0]  a;
      logic        dp;
      logic        dn;
      logic [23:0] ea;
      logic [7:0]  eb;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      else npass++;
   endtask

   // Entered just after a negedge; drives samples until the selected instance raises valid.
   task automatic win_body(input bit s, input bit gap, input int start_at, output int cyc);
      cyc = 0;
      while (((s ? valid_s : valid_a) == 1'b0) && cyc < 40) begin
         en      = gap ? ((cyc % 2) == 1) : 1'b1;
         start_a = (cyc == start_at);
         @(negedge CLK);
         cyc++;
      end
      en      = 1'b0;
      start_a = 1'b0;
   endtask

   task automatic begin_a();
      start_a = 1'b1;
      @(negedge CLK);
      start_a = 1'b0;
   endtask

   task automatic ack_a(input bit st);
      ready_a = 1'b1;
      start_a = st;
      @(negedge CLK);
      ready_a = 1'b0;
      start_a = 1'b0;
   endtask

   initial begin
      int cyc;
      bit bad;
      vecs[0] = '{3'b101, 1'b1, 1'b0, 24'h080008, 8'h08};
      vecs[1] = '{3'b111, 1'b0, 1'b1, 24'hF8F8F8, 8'hF8};
      vecs[2] = '{3'b111, 1'b1, 1'b1, 24'h000000, 8'h00};
      vecs[3] = '{3'b010, 1'b1, 1'b0, 24'h000800, 8'h08};
      vecs[4] = '{3'b110, 1'b0, 1'b1, 24'hF8F800, 8'hF8};
      vecs[5] = '{3'b000, 1'b1, 1'b0, 24'h000000, 8'h08};

      INIT = 1'b0; start_a = 0; start_s = 0; ready_a = 0; ready_s = 0;
      en = 0; delta_p = 0; delta_n = 0; atj = '0;
      repeat (2) @(negedge CLK);
      chk("rst_alpha", galpha_a, 0);
      chk("rst_beta", gbeta_a, 0);
      chk("rst_valid", valid_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_sat", sat_a, 0);
      chk("rst_alpha_s", galpha_s, 0);
      INIT = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 6; i++) begin
         begin_a();
         atj = vecs[i].a; delta_p = vecs[i].dp; delta_n = vecs[i].dn;
         win_body(1'b0, 1'b0, -1, cyc);
         chk($sformatf("v%0d_latency", i), cyc, 8);
         chk($sformatf("v%0d_alpha", i), galpha_a, vecs[i].ea);
         chk($sformatf("v%0d_beta", i), gbeta_a, vecs[i].eb);
         chk($sformatf("v%0d_sat", i), sat_a, 0);
         ack_a(1'b0);
         chk($sformatf("v%0d_valid_drop", i), valid_a, 0);
         chk($sformatf("v%0d_idle", i), busy_a, 0);
      end

      // Gapped window, backpressure, then back-to-back restart.
      begin_a();
      atj = 3'b111; delta_p = 1; delta_n = 0;
      win_body(1'b0, 1'b1, -1, cyc);
      chk("gap_latency", cyc, 16);
      chk("gap_alpha", galpha_a, 24'h080808);
      bad = 0;
      repeat (5) begin
         @(negedge CLK);
         if (valid_a !== 1'b1 || galpha_a !== 24'h080808 || gbeta_a !== 8'h08) bad = 1;
      end
      chk("hold_stable", bad, 0);
      ack_a(1'b1);
      chk("b2b_busy", busy_a, 1);
      chk("b2b_valid", valid_a, 0);
      chk("b2b_keep", galpha_a, 24'h080808);
      atj = 3'b010;
      win_body(1'b0, 1'b0, -1, cyc);
      chk("b2b_latency", cyc, 8);
      chk("b2b_alpha", galpha_a, 24'h000800);
      chk("b2b_beta", gbeta_a, 8'h08);
      ack_a(1'b0);

      // Start pulse during ACCUM must not restart the window.
      begin_a();
      atj = 3'b101; delta_p = 1; delta_n = 0;
      win_body(1'b0, 1'b0, 3, cyc);
      chk("ign_latency", cyc, 8);
      chk("ign_alpha", galpha_a, 24'h080008);
      chk("ign_beta", gbeta_a, 8'h08);
      ack_a(1'b0);

      // Saturation on the narrow instance.
      start_s = 1; @(negedge CLK); start_s = 0;
      atj = 3'b111; delta_p = 1; delta_n = 0;
      win_body(1'b1, 1'b0, -1, cyc);
      chk("satp_latency", cyc, 16);
      chk("satp_alpha", galpha_s, 12'h777);
      chk("satp_beta", gbeta_s, 4'h7);
      chk("satp_sat", sat_s, 4'hF);
      ready_s = 1; start_s = 1; @(negedge CLK); ready_s = 0; start_s = 0;
      chk("sat_cleared", sat_s, 0);
      delta_p = 0; delta_n = 1;
      win_body(1'b1, 1'b0, -1, cyc);
      chk("satn_latency", cyc, 16);
      chk("satn_alpha", galpha_s, 12'h888);
      chk("satn_beta", gbeta_s, 4'h8);
      chk("satn_sat", sat_s, 4'hF);
      ready_s = 1; @(negedge CLK); ready_s = 0;

      // Reset mid-window.
      begin_a();
      atj = 3'b111; delta_p = 1; delta_n = 0; en = 1;
      repeat (3) @(negedge CLK);
      en = 0;
      INIT = 1'b0;
      #1;
      chk("arst_alpha", galpha_a, 0);
      chk("arst_beta", gbeta_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_sat_s", sat_s, 0);
      chk("arst_alpha_s", galpha_s, 0);
      @(negedge CLK);
      INIT = 1'b1;
      en = 1;
      bad = 0;
      repeat (20) begin
         @(negedge CLK);
         if (valid_a !== 1'b0 || busy_a !== 1'b0) bad = 1;
      end
      en = 0;
      chk("arst_no_valid", bad, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/nn_dnode_acc.md
Name: nn_dnode_acc

Overview:
Windowed backpropagation gradient node for the stochastic fully-connected network, one per output node k.
- Forms per-input stochastic gradient products of a signed delta bitstream with the previous-layer activations atj.
- Integrates the products, and the bias gradient, over a programmable window of enabled clock samples into saturating signed counters.
- Presents the binary gradient words to the weight-update logic through a valid/ready handshake.

Parameters:
NN, 3, number of previous-layer inputs (alpha channels)
NB, 16, signed accumulator/output width per channel, two's complement
WIN_LOG2, 8, window length W = 2^WIN_LOG2 enabled samples

Ports:
CLK  input  1  clock, all state on rising edge
INIT  input  1  reset, asynchronous active-low; clears all state
start  input  1  request a new accumulation window (sampled in IDLE, or in DONE together with grad_ready)
en  input  1  stream sample valid; counters and window count advance only when high
delta_p  input  1  positive part of the split-unipolar delta stream (dC/dzk > 0)
delta_n  input  1  negative part of the split-unipolar delta stream
atj  input  NN  activation bitstreams of previous-layer nodes
grad_alpha  output  NN*NB  accumulated dC/dalpha; channel n in bits [n*NB +: NB]
grad_beta  output  NB  accumulated dC/dbeta
grad_valid  output  1  gradient words valid
grad_ready  input  1  consumer accepts the words
busy  output  1  high in ACCUM and DONE
sat  output  NN+1  sticky per-counter saturation flags; bit NN is beta

Behaviour:
- Reset (INIT=0, asynchronous): state IDLE; all counters, grad_alpha, grad_beta, window count and sat are 0; grad_valid=0; busy=0.
- States:
  - IDLE: start=1 clears counters, window count and sat, then enters ACCUM next cycle.
  - ACCUM: start is ignored.
  - DONE: grad_valid=1. Outputs hold until grad_valid&grad_ready.
    - On handshake with start=0: go to IDLE.
    - On handshake with start=1: clear and go to ACCUM (back-to-back windows, no IDLE cycle).
- Per-channel step in ACCUM when en=1:
  - inc = atj[n]&delta_p&~delta_n gives +1.
  - dec = atj[n]&delta_n&~delta_p gives -1.
  - Otherwise 0, including delta_p=delta_n=1, which cancels.
- Beta step: same rule with atj forced to 1.
- Saturating arithmetic: clamp to [-2^(NB-1), 2^(NB-1)-1]. Once clamping occurs, sat bit sets and stays set until the next window clear.
- Window count increments on each enabled sample. On the enabled sample with count = W-1:
  - that sample is included in the counters;
  - counters are copied to grad_alpha/grad_beta;
  - state goes to DONE, so grad_valid rises the next cycle.
- Latency: grad_valid asserts exactly one cycle after the W-th enabled sample. en=0 cycles stretch the window without changing any counter.
- grad_alpha/grad_beta change only on the transfer into DONE. Between windows they keep the last result.
- INIT=0 mid-window aborts immediately: partial sums are discarded and no grad_valid is produced.
- NB ≤ WIN_LOG2 is legal. Saturation is then reachable and is reported through sat.

Decomposition:
- Shared package nn_pkg:
  - state enum {IDLE, ACCUM, DONE};
  - sat_add function (NB-wide signed value plus step in {-1,0,+1}, returns value and overflow flag);
  - localparams for min/max signed bounds.
- One sub-module: nn_grad_chan. It holds one channel's step decode and saturating counter (inputs a, delta_p, delta_n, en, clr; outputs count, sat).
  - Instantiate it NN times for alpha, plus once with a tied high for beta.
  - The top level holds the FSM, window counter and output registers.

Test Plan:
- Sign and channel mapping (NN=3, NB=8, WIN_LOG2=3): atj=3'b101, delta_p=1, delta_n=0, en=1 for 8 cycles → grad_alpha={8,0,8} (ch2..ch0), grad_beta=8, grad_valid one cycle after the 8th sample, sat=0.
- Negative and cancel: first window with atj=3'b111, delta_n=1 → all alpha and beta = -8 (8'hF8). Second window with delta_p=delta_n=1 → all 0.
- Gaps and backpressure: en toggling 1,0,1,0… → grad_valid arrives after 8 enabled samples (16 cycles). Hold grad_ready=0 for 5 cycles → outputs and grad_valid stable. Raise grad_ready with start=1 → ACCUM next cycle, counters cleared.
- Saturation (NB=4, WIN_LOG2=4): delta_p=1, atj all 1 for 16 samples → every word = 7, sat=4'b1111. The next window with delta_n=1 → every word = -8, sat=4'b1111 (sat is reset on clear, then set again by clamping).
- Reset mid-window: INIT=0 after 3 samples → everything 0 and state IDLE asynchronously. After release with no start → grad_valid stays 0 for 20 cycles.
- Start ignored in ACCUM: pulse start at sample 4 → window still completes at sample 8 with unchanged results.
